// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and the alignment rule for the load/store unit
// that sits in front of the word-wide data memory.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        RESP
    } lsu_state_t;

    // The reserved size also counts as misaligned, so one check covers every rejected request.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Request/response handshake plus the dmem port of the load/store unit.
// The master side is execute + dmem; the slave side is the LSU itself.
interface lsu_mem_stage_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_address;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_err;
    logic [31:0]           resp_rdata;
    logic [ADDR_WIDTH-1:0] dmem_address;
    logic [31:0]           dmem_writeData;
    logic                  dmem_memWrite;
    logic                  dmem_memRead;
    logic [31:0]           dmem_readData;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
        output dmem_readData,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  dmem_address, dmem_writeData, dmem_memWrite, dmem_memRead
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
        input  dmem_readData,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output dmem_address, dmem_writeData, dmem_memWrite, dmem_memRead
    );

endinterface

// File: rtl/lsu_lane_mux.sv
// Little-endian lane steering: extracts and extends a loaded byte/half, and
// merges a sub-word store value into the word read back from dmem.
module lsu_lane_mux
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_value,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel    = word[{lane, 3'b000} +: 8];
        half_sel    = lane[1] ? word[31:16] : word[15:0];
        load_value  = 32'h0;
        merged_word = word;
        case (size)
            SZ_BYTE: begin
                load_value = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                merged_word[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_value = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
                if (lane[1]) begin
                    merged_word[31:16] = wdata[15:0];
                end else begin
                    merged_word[15:0] = wdata[15:0];
                end
            end
            SZ_WORD: begin
                load_value  = word;
                merged_word = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit between execute and dmem: byte/half/word accesses mapped onto
// a word-wide memory, sub-word stores by read-modify-write, misalignment reported.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter bit WORD_INDEXED = 1'b1
) (
    input logic            clock,
    input logic            reset,
    lsu_mem_stage_if.slave bus
);

    lsu_state_t            state, state_next;
    logic [1:0]            lane_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic                  err_q;
    logic [31:0]           wdata_q;
    logic [31:0]           merge_q;
    logic [31:0]           resp_rdata_q;
    logic [ADDR_WIDTH-1:0] dmem_address_q;
    logic [ADDR_WIDTH-1:0] word_address;
    logic                  accept;
    logic                  req_err;
    logic [31:0]           mux_word;
    logic [31:0]           load_value;
    logic [31:0]           merged_word;

    assign accept       = bus.req_valid && (state == IDLE);
    assign req_err      = is_misaligned(bus.req_size, bus.req_address[1:0]);
    assign word_address = WORD_INDEXED ? (bus.req_address >> 2)
                                       : {bus.req_address[ADDR_WIDTH-1:2], 2'b00};
    assign mux_word     = (state == RMW_WR) ? merge_q : bus.dmem_readData;

    assign bus.dmem_address = dmem_address_q;
    assign bus.resp_rdata   = resp_rdata_q;

    lsu_lane_mux u_lane_mux (
        .word        (mux_word),
        .lane        (lane_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .wdata       (wdata_q),
        .load_value  (load_value),
        .merged_word (merged_word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes are forced low while reset is high because dmem writes on level, not edge.
    always_comb begin
        state_next         = state;
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.resp_err       = 1'b0;
        bus.dmem_memRead   = 1'b0;
        bus.dmem_memWrite  = 1'b0;
        bus.dmem_writeData = 32'h0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (accept) begin
                    if (req_err) begin
                        state_next = RESP;
                    end else if (!bus.req_write) begin
                        state_next = LOAD;
                    end else if (bus.req_size == SZ_WORD) begin
                        state_next = STORE;
                    end else begin
                        state_next = RMW_RD;
                    end
                end
            end
            LOAD: begin
                bus.dmem_memRead = 1'b1;
                state_next       = RESP;
            end
            STORE: begin
                bus.dmem_memWrite  = 1'b1;
                bus.dmem_writeData = wdata_q;
                state_next         = RESP;
            end
            RMW_RD: begin
                bus.dmem_memRead = 1'b1;
                state_next       = RMW_WR;
            end
            RMW_WR: begin
                bus.dmem_memWrite  = 1'b1;
                bus.dmem_writeData = merged_word;
                state_next         = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            bus.dmem_memRead  = 1'b0;
            bus.dmem_memWrite = 1'b0;
        end
    end

    // Error requests never update the dmem address, so memory is not even pointed at.
    always_ff @(posedge clock) begin
        if (reset) begin
            lane_q         <= 2'b00;
            size_q         <= 2'b00;
            unsigned_q     <= 1'b0;
            err_q          <= 1'b0;
            wdata_q        <= 32'h0;
            merge_q        <= 32'h0;
            resp_rdata_q   <= 32'h0;
            dmem_address_q <= '0;
        end else begin
            if (accept) begin
                lane_q       <= bus.req_address[1:0];
                size_q       <= bus.req_size;
                unsigned_q   <= bus.req_unsigned;
                err_q        <= req_err;
                wdata_q      <= bus.req_wdata;
                resp_rdata_q <= 32'h0;
                if (!req_err) begin
                    dmem_address_q <= word_address;
                end
            end
            if (state == LOAD) begin
                resp_rdata_q <= load_value;
            end
            if (state == RMW_RD) begin
                merge_q <= bus.dmem_readData;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed table, reset and handshake
// corner sequences, and random requests against an arithmetic memory model.
module tb_lsu_mem_stage;
    import lsu_pkg::*;

    localparam int AW = 32;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    lsu_mem_stage_if #(.ADDR_WIDTH(AW)) bus();

    lsu_mem_stage #(.ADDR_WIDTH(AW), .WORD_INDEXED(1'b1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        expErr;
        logic [31:0] expData;
        int          expLat;
    } vec_t;

    logic [31:0] mem [256];
    logic [31:0] refMem [256];
    logic        pokeEn;
    logic [7:0]  pokeIdx;
    logic [31:0] pokeData;

    int          tests = 0;
    int          fails = 0;
    int          writeCycles = 0;
    int          readCycles = 0;
    int          respCycles = 0;
    int          overlapCount = 0;
    int          respDouble = 0;
    logic        prevResp = 1'b0;
    logic [31:0] lastStrobeAddr = 32'h0;

    // Word-wide dmem model with combinational read; pokes preload it from the bench.
    assign bus.dmem_readData = mem[bus.dmem_address[7:0]];

    always @(posedge clock) begin
        if (pokeEn) begin
            mem[pokeIdx] <= pokeData;
        end else if (bus.dmem_memWrite) begin
            mem[bus.dmem_address[7:0]] <= bus.dmem_writeData;
        end
    end

    always @(negedge clock) begin
        if (bus.dmem_memRead && bus.dmem_memWrite) overlapCount++;
        if (bus.dmem_memWrite) writeCycles++;
        if (bus.dmem_memRead) readCycles++;
        if (bus.dmem_memRead || bus.dmem_memWrite) lastStrobeAddr = bus.dmem_address;
        if (bus.resp_valid && prevResp) respDouble++;
        if (bus.resp_valid) respCycles++;
        prevResp = bus.resp_valid;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic pokeWord(input logic [7:0] idx, input logic [31:0] data);
        @(negedge clock);
        pokeEn   = 1'b1;
        pokeIdx  = idx;
        pokeData = data;
        refMem[idx] = data;
        @(posedge clock);
        #1 pokeEn = 1'b0;
    endtask

    // Reference behaviour from the access rules using plain shifts and masks.
    task automatic modelAccess(input logic wr, input logic [1:0] sz, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] word,
                               output logic err, output logic [31:0] rdata, output int lat,
                               output logic [31:0] newWord);
        int          sh;
        logic [31:0] mask;
        logic [31:0] v;
        err     = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
        rdata   = 32'h0;
        newWord = word;
        lat     = 1;
        if (err) return;
        if (sz == 2'd0) begin
            sh = int'(addr[1:0]) * 8;
            mask = 32'hFF;
        end else if (sz == 2'd1) begin
            sh = int'(addr[1]) * 16;
            mask = 32'hFFFF;
        end else begin
            sh = 0;
            mask = 32'hFFFF_FFFF;
        end
        if (wr) begin
            newWord = (word & ~(mask << sh)) | ((wd & mask) << sh);
            lat     = (sz == 2'd2) ? 2 : 3;
        end else begin
            v = (word >> sh) & mask;
            if (!uns && sz != 2'd2 && v > (mask >> 1)) v = v | ~mask;
            rdata = v;
            lat   = 2;
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 output logic gotErr, output logic [31:0] gotData, output int lat,
                                 output int wrCyc, output int rdCyc, output logic [31:0] strobeAddr);
        int   w0;
        int   r0;
        int   waitCount;
        logic gotResp;
        gotErr = 1'b0; gotData = 32'h0; lat = -1; wrCyc = 0; rdCyc = 0; strobeAddr = 32'h0;
        @(negedge clock);
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_address  = addr;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        waitCount = 0;
        while (!bus.req_ready && waitCount < 10) begin
            @(negedge clock);
            waitCount++;
        end
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: req_ready got 0, expected 1");
            return;
        end
        @(posedge clock);
        w0 = writeCycles;
        r0 = readCycles;
        gotResp = 1'b0;
        waitCount = 0;
        while (!gotResp && waitCount < 10) begin
            @(negedge clock);
            bus.req_valid = 1'b0;
            waitCount++;
            #1;
            if (bus.resp_valid) begin
                gotResp = 1'b1;
                gotErr  = bus.resp_err;
                gotData = bus.resp_rdata;
                lat     = waitCount;
            end
        end
        wrCyc      = writeCycles - w0;
        rdCyc      = readCycles - r0;
        strobeAddr = lastStrobeAddr;
    endtask

    task automatic runRequest(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic expErr, input logic [31:0] expData, input int expLat);
        logic        gotErr;
        logic [31:0] gotData;
        logic [31:0] strobeAddr;
        int          lat;
        int          wrCyc;
        int          rdCyc;
        logic        mErr;
        logic [31:0] mData;
        logic [31:0] newWord;
        int          mLat;
        modelAccess(wr, sz, uns, addr, wd, refMem[addr[9:2]], mErr, mData, mLat, newWord);
        applyStimulus(wr, sz, uns, addr, wd, gotErr, gotData, lat, wrCyc, rdCyc, strobeAddr);
        checkOutput({name, "_err"}, 32'(gotErr), 32'(expErr));
        checkOutput({name, "_rdata"}, gotData, expData);
        checkOutput({name, "_latency"}, lat, expLat);
        checkOutput({name, "_writes"}, wrCyc, (wr && !expErr) ? 1 : 0);
        checkOutput({name, "_reads"}, rdCyc, (!expErr && (!wr || sz != SZ_WORD)) ? 1 : 0);
        if (!expErr) checkOutput({name, "_dmem_addr"}, strobeAddr, {2'b00, addr[31:2]});
        if (!mErr) refMem[addr[9:2]] = newWord;
        if (wr) checkOutput({name, "_mem"}, mem[addr[9:2]], refMem[addr[9:2]]);
    endtask

    initial begin
        vec_t        vecs[14];
        int          waitCount;
        int          respBase;
        int          respSeen;
        logic        acceptPending;
        logic        earlyAccept;
        logic [31:0] firstData;
        logic        rWr;
        logic [1:0]  rSz;
        logic        rUns;
        logic [31:0] rAddr;
        logic [31:0] rWd;
        logic        mErr;
        logic [31:0] mData;
        logic [31:0] newWord;
        int          mLat;

        vecs[0]  = '{"sw_10",       1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        2};
        vecs[1]  = '{"lw_10",       1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 2};
        vecs[2]  = '{"sb_21",       1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h000000AA, 1'b0, 32'h0,        3};
        vecs[3]  = '{"lw_20",       1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0,        1'b0, 32'h1122AA44, 2};
        vecs[4]  = '{"lb_32",       1'b0, SZ_BYTE, 1'b0, 32'h32, 32'h0,        1'b0, 32'hFFFFFFFF, 2};
        vecs[5]  = '{"lbu_32",      1'b0, SZ_BYTE, 1'b1, 32'h32, 32'h0,        1'b0, 32'h000000FF, 2};
        vecs[6]  = '{"lh_32",       1'b0, SZ_HALF, 1'b0, 32'h32, 32'h0,        1'b0, 32'hFFFF80FF, 2};
        vecs[7]  = '{"lb_30",       1'b0, SZ_BYTE, 1'b0, 32'h30, 32'h0,        1'b0, 32'h00000001, 2};
        vecs[8]  = '{"lhu_32",      1'b0, SZ_HALF, 1'b1, 32'h32, 32'h0,        1'b0, 32'h000080FF, 2};
        vecs[9]  = '{"lh_41_err",   1'b0, SZ_HALF, 1'b0, 32'h41, 32'h0,        1'b1, 32'h0,        1};
        vecs[10] = '{"sw_42_err",   1'b1, SZ_WORD, 1'b0, 32'h42, 32'h12345678, 1'b1, 32'h0,        1};
        vecs[11] = '{"rsvd_44_err", 1'b0, 2'b11,   1'b0, 32'h44, 32'h0,        1'b1, 32'h0,        1};
        vecs[12] = '{"sh_42",       1'b1, SZ_HALF, 1'b0, 32'h42, 32'h0000BEEF, 1'b0, 32'h0,        3};
        vecs[13] = '{"lw_40",       1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0,        1'b0, 32'hBEEFAAAA, 2};

        reset            = 1'b1;
        pokeEn           = 1'b0;
        pokeIdx          = 8'h0;
        pokeData         = 32'h0;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_address  = 32'h0;
        bus.req_wdata    = 32'h0;

        for (int i = 0; i < 256; i++) begin
            pokeWord(8'(i), (32'(i) * 32'h01010101) ^ 32'hA5A5A5A5);
        end

        @(negedge clock);
        #1;
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("reset_resp_err", 32'(bus.resp_err), 32'd0);
        checkOutput("reset_resp_rdata", bus.resp_rdata, 32'h0);
        checkOutput("reset_dmem_address", bus.dmem_address, 32'h0);
        checkOutput("reset_dmem_writeData", bus.dmem_writeData, 32'h0);
        checkOutput("reset_dmem_memWrite", 32'(bus.dmem_memWrite), 32'd0);
        checkOutput("reset_dmem_memRead", 32'(bus.dmem_memRead), 32'd0);
        reset = 1'b0;

        pokeWord(8'd8, 32'h11223344);
        pokeWord(8'd12, 32'h80FF7F01);
        pokeWord(8'd16, 32'h5555AAAA);

        $display("[TB] directed table");
        for (int i = 0; i < 14; i++) begin
            runRequest(vecs[i].name, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                       vecs[i].expErr, vecs[i].expData, vecs[i].expLat);
        end
        checkOutput("mem_20_after_sb", mem[8], 32'h1122AA44);
        checkOutput("mem_30_untouched", mem[12], 32'h80FF7F01);

        $display("[TB] reset during RMW_WR");
        pokeWord(8'd20, 32'hCAFEF00D);
        @(negedge clock);
        bus.req_write    = 1'b1;
        bus.req_size     = SZ_HALF;
        bus.req_unsigned = 1'b0;
        bus.req_address  = 32'h50;
        bus.req_wdata    = 32'h00001234;
        bus.req_valid    = 1'b1;
        waitCount = 0;
        while (!bus.req_ready && waitCount < 10) begin
            @(negedge clock);
            waitCount++;
        end
        checkOutput("rst_accept_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clock);
        respBase = respCycles;
        @(negedge clock);
        bus.req_valid = 1'b0;
        #1 checkOutput("rst_rmw_rd_read", 32'(bus.dmem_memRead), 32'd1);
        @(negedge clock);
        #1 checkOutput("rst_rmw_wr_write", 32'(bus.dmem_memWrite), 32'd1);
        reset = 1'b1;
        #1 checkOutput("rst_write_gated", 32'(bus.dmem_memWrite), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1 checkOutput("rst_ready_after", 32'(bus.req_ready), 32'd1);
        repeat (3) @(negedge clock);
        #1;
        checkOutput("rst_no_resp", respCycles - respBase, 32'd0);
        checkOutput("rst_mem_50", mem[20], 32'hCAFEF00D);

        $display("[TB] req_valid held across load then store");
        @(negedge clock);
        bus.req_write    = 1'b0;
        bus.req_size     = SZ_WORD;
        bus.req_unsigned = 1'b0;
        bus.req_address  = 32'h30;
        bus.req_wdata    = 32'h0;
        bus.req_valid    = 1'b1;
        checkOutput("held_first_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        bus.req_write   = 1'b1;
        bus.req_address = 32'h60;
        bus.req_wdata   = 32'h0BADF00D;
        respSeen      = 0;
        acceptPending = 1'b0;
        earlyAccept   = 1'b0;
        firstData     = 32'h0;
        for (int k = 0; k < 12 && respSeen < 2; k++) begin
            if (k > 0) @(negedge clock);
            if (acceptPending) begin
                bus.req_valid = 1'b0;
                acceptPending = 1'b0;
            end
            #1;
            if (bus.resp_valid) begin
                respSeen++;
                if (respSeen == 1) firstData = bus.resp_rdata;
            end
            if (bus.req_valid && bus.req_ready) begin
                if (respSeen == 0) earlyAccept = 1'b1;
                acceptPending = 1'b1;
            end
        end
        bus.req_valid = 1'b0;
        refMem[24] = 32'h0BADF00D;
        checkOutput("held_resp_count", respSeen, 32'd2);
        checkOutput("held_early_accept", 32'(earlyAccept), 32'd0);
        checkOutput("held_load_data", firstData, 32'h80FF7F01);
        checkOutput("held_store_mem", mem[24], 32'h0BADF00D);

        $display("[TB] random requests");
        for (int i = 0; i < 80; i++) begin
            rWr   = 1'($urandom_range(0, 1));
            rSz   = 2'($urandom_range(0, 3));
            rUns  = 1'($urandom_range(0, 1));
            rAddr = 32'($urandom_range(0, 1023));
            rWd   = $urandom;
            modelAccess(rWr, rSz, rUns, rAddr, rWd, refMem[rAddr[9:2]], mErr, mData, mLat, newWord);
            runRequest($sformatf("rnd%0d", i), rWr, rSz, rUns, rAddr, rWd, mErr, mData, mLat);
        end

        repeat (2) @(negedge clock);
        #1;
        checkOutput("strobe_overlap", overlapCount, 32'd0);
        checkOutput("resp_longer_than_one_cycle", respDouble, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit placed directly upstream of the word-wide data memory. It sits between the execute stage and dmem.
- Takes byte-addressed load/store requests of byte, half or word size. Converts them to word-indexed dmem accesses.
- Sub-word stores use read-modify-write. Loaded lanes are zero- or sign-extended.
- Reports misaligned accesses instead of touching memory. Uses a valid/ready request handshake and a one-cycle response pulse.

Parameters:
- ADDR_WIDTH, 32, width of the byte address from execute and of the dmem address.
- WORD_INDEXED, 1, 1: dmem address = byte address >> 2; 0: dmem address = byte address with bits [1:0] forced to 0.

Ports:
- clock  input  1  single clock for all state.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_address  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  store data; the value sits in the low lanes for sub-word stores.
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  misaligned or reserved size; valid with resp_valid.
- resp_rdata  output  32  extended load result; 0 for stores and errors.
- dmem_address  output  ADDR_WIDTH  to dmem address.
- dmem_writeData  output  32  to dmem writeData.
- dmem_memWrite  output  1  to dmem memWrite.
- dmem_memRead  output  1  to dmem memRead.
- dmem_readData  input  32  from dmem readData; combinational, valid the same cycle as the address.

Behaviour:
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- Reset values: state IDLE. resp_valid, resp_err, dmem_memWrite and dmem_memRead are 0. resp_rdata, dmem_address and dmem_writeData are 0. All latched request fields are 0.
- On accept, latch address, size, write, unsigned and wdata.
- Error check on accept: size 11, half with addr[0]=1, or word with addr[1:0]!=0 is an error.
  - On error, go straight to RESP with resp_err=1 and resp_rdata=0.
  - No dmem strobe is ever raised for an error request.
- Transitions from IDLE on accept:
  - Error → RESP.
  - Load → LOAD.
  - Word store → STORE.
  - Byte or half store → RMW_RD.
- LOAD: dmem_memRead=1. Capture dmem_readData at the edge, extract the lane and extend it into resp_rdata. → RESP.
- STORE: dmem_memWrite=1, dmem_writeData = wdata. → RESP.
- RMW_RD: dmem_memRead=1. Capture dmem_readData into the merge register. → RMW_WR.
- RMW_WR: dmem_memWrite=1, dmem_writeData = merge register with the target lane replaced from wdata. → RESP.
- RESP: resp_valid=1 for exactly one cycle, then → IDLE.
  - req_ready is low in RESP, so back-to-back requests are spaced by at least one IDLE cycle.
- Lane rules (little-endian):
  - Byte lane = addr[1:0].
  - Half lane = addr[1]; lower half is bits [15:0], upper half is bits [31:16].
  - Sign-extend from bit 7 (byte) or bit 15 (half) when req_unsigned=0.
  - req_unsigned is ignored for word loads and all stores.
- Latency from the accepting edge to the resp_valid cycle:
  - Error: 1 cycle.
  - Load and word store: 2 cycles.
  - Sub-word store: 3 cycles.
- dmem strobes: dmem_memRead and dmem_memWrite are decoded from state and are never both 1 in the same cycle.
  - dmem_address is held constant from LOAD, STORE or RMW_RD through the following RMW_WR.
  - In IDLE and RESP, dmem_address holds its last value and both strobes are 0.
- Reset mid-operation:
  - dmem_memWrite and dmem_memRead are gated low combinationally while reset=1, because dmem writes level-sensitively.
  - Any in-flight request is dropped: no response and no partial write.
- req_valid while busy is ignored; the requester must hold it until accepted.

Decomposition:
- Shared package lsu_pkg:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum.
  - Function is_misaligned(size, addr[1:0]).
- One sub-module, lsu_lane_mux (combinational). It performs load lane extract/extend and store lane merge.
  - Inputs: word, lane, size, unsigned, wdata.
  - Outputs: load_value, merged_word.

Test Plan:
- Word store 0xDEADBEEF to byte address 0x10, then word load from 0x10 → dmem_address=4 (WORD_INDEXED=1), memWrite for exactly one cycle, then resp_rdata=0xDEADBEEF, resp_err=0.
- Memory word 0x11223344 at 0x20; byte store 0xAA to 0x21 → RMW_RD then RMW_WR cycles; the word becomes 0x1122AA44 and resp_valid arrives 3 cycles after accept.
- Word 0x80FF7F01 at 0x30:
  - signed lb 0x32 → 0xFFFFFFFF.
  - unsigned lbu 0x32 → 0x000000FF.
  - signed lh 0x32 → 0xFFFF80FF.
  - signed lb 0x30 → 0x00000001.
- Half load from 0x41 and word store to 0x42 → resp_err=1 and resp_rdata=0 one cycle after accept; dmem strobes stay 0 throughout; memory is unchanged.
- Reset asserted during RMW_WR of a half store to 0x50 → dmem_memWrite=0 that cycle, word at 0x50 unchanged, no resp_valid, IDLE with req_ready=1 after reset.
- req_valid held high across a load followed by a store → second request is accepted only after RESP; strobes never overlap; resp_valid is seen twice, one cycle each.
